// File: rtl/serial_magcompare_pkg.sv
// Shared types and sizing helpers for the digit-serial magnitude comparator.
package serial_magcompare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIGIT_BITS = 2;

  function automatic int ndigits(input int width);
    return width / DIGIT_BITS;
  endfunction

  // A single-digit operand still needs a one-bit index register.
  function automatic int idx_width(input int width);
    int n;
    n = ndigits(width);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_magcompare_digit.sv
// One 2-bit digit compare folded into the running LT/GT pair; earlier digits dominate.
module magcompare_digit
  import serial_magcompare_pkg::*;
(
  input  logic [DIGIT_BITS-1:0] a_dig,
  input  logic [DIGIT_BITS-1:0] b_dig,
  input  logic                  lt_acc,
  input  logic                  gt_acc,
  output logic                  lt_next,
  output logic                  gt_next
);

  logic dig_lt;
  logic dig_gt;

  assign dig_lt  = (a_dig < b_dig);
  assign dig_gt  = (a_dig > b_dig);
  assign gt_next = gt_acc | (~lt_acc & dig_gt);
  assign lt_next = lt_acc | (~gt_acc & dig_lt);

endmodule

// File: rtl/serial_magcompare.sv
// Iterative MSB-first magnitude comparator, 2 bits per cycle with early exit on the first unequal digit.
module serial_magcompare
  import serial_magcompare_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int NDIGITS = ndigits(WIDTH);
  localparam int IDX_W   = idx_width(WIDTH);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_magcompare: WIDTH must be even and >= 2");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lt_acc_q, lt_acc_d;
  logic             gt_acc_q, gt_acc_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;

  logic             accept;
  logic             last_digit;
  logic             fold_lt;
  logic             fold_gt;
  logic [WIDTH-1:0] a_biased;
  logic [WIDTH-1:0] b_biased;

  // Signed compare becomes unsigned by flipping both sign bits at capture.
  assign a_biased = a ^ {is_signed, {(WIDTH-1){1'b0}}};
  assign b_biased = b ^ {is_signed, {(WIDTH-1){1'b0}}};

  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign last_digit = (idx_q == IDX_W'(NDIGITS - 1));
  assign out_valid  = (state_q == DONE);
  assign lt         = lt_q;
  assign gt         = gt_q;
  assign eq         = eq_q;

  // Operands shift left each cycle so the current digit always sits at the top.
  magcompare_digit u_digit (
    .a_dig   (opa_q[WIDTH-1 -: DIGIT_BITS]),
    .b_dig   (opb_q[WIDTH-1 -: DIGIT_BITS]),
    .lt_acc  (lt_acc_q),
    .gt_acc  (gt_acc_q),
    .lt_next (fold_lt),
    .gt_next (fold_gt)
  );

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    idx_d    = idx_q;
    lt_acc_d = lt_acc_q;
    gt_acc_d = gt_acc_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;

    case (state_q)
      SCAN: begin
        opa_d    = opa_q << DIGIT_BITS;
        opb_d    = opb_q << DIGIT_BITS;
        idx_d    = idx_q + IDX_W'(1);
        lt_acc_d = fold_lt;
        gt_acc_d = fold_gt;
        if (fold_lt | fold_gt | last_digit) begin
          state_d = DONE;
          lt_d    = fold_lt;
          gt_d    = fold_gt;
          eq_d    = ~fold_lt & ~fold_gt;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept wins from IDLE and from a consumed DONE (back-to-back).
    if (accept) begin
      state_d  = SCAN;
      opa_d    = a_biased;
      opb_d    = b_biased;
      idx_d    = '0;
      lt_acc_d = 1'b0;
      gt_acc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      idx_q    <= '0;
      lt_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      idx_q    <= idx_d;
      lt_acc_q <= lt_acc_d;
      gt_acc_q <= gt_acc_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
    end
  end

endmodule

// File: tb/tb_serial_magcompare.sv
// Directed-vector bench for serial_magcompare: results, latency, stalls, back-to-back accept and reset abort.
module tb_serial_magcompare;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic        lt;
  logic        gt;
  logic        eq;

  int total_count;
  int bad_count;

  serial_magcompare #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .gt        (gt),
    .eq        (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_count++;
    if (actual !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Latency counts edges after the accept edge until out_valid is seen.
  task automatic applyStimulus(input string tag, input logic [31:0] va, input logic [31:0] vb,
                               input logic sgn, input logic exp_lt, input logic exp_gt,
                               input logic exp_eq, input int exp_lat);
    int cyc;
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a         = va;
    b         = vb;
    is_signed = sgn;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a         = ~va;
    b         = va ^ 32'h5A5A_A5A5;
    is_signed = ~sgn;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, exp_lat);
    checkOutput({tag, "_result"}, {29'd0, lt, gt, eq}, {29'd0, exp_lt, exp_gt, exp_eq});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_released"}, {28'd0, out_valid, lt, gt, eq}, 32'd0);
  endtask

  initial begin
    int  cyc;
    logic seen_valid;
    total_count = 0;
    bad_count   = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    is_signed   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {27'd0, in_ready, out_valid, lt, gt, eq}, 32'h10);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    applyStimulus("msb_diff",     32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus("equal",        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    applyStimulus("neg1_vs_1_s",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("neg1_vs_1_u",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus("mid_digit",    32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 1'b0, 14);
    applyStimulus("min_vs_max_s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("min_vs_max_u", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus("neg2_vs_neg3", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b1, 1'b0, 16);
    applyStimulus("pos_vs_zero_s",32'h4000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus("digit10",      32'h0000_0400, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0, 11);
    applyStimulus("equal_signed", 32'h8000_0001, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 16);

    $display("[TB] stall and back-to-back accept");
    a = 32'h0000_0002; b = 32'h0000_0003; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("stall_latency", cyc, 16);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_hold", {29'd0, lt, gt, eq}, 32'h4);
      checkOutput("stall_in_ready", {30'd0, in_ready, out_valid}, 32'h1);
      @(posedge clk); #1;
    end
    a = 32'h8000_0000; b = 32'h0000_0000; is_signed = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("b2b_scanning", {28'd0, out_valid, lt, gt, eq}, 32'd0);
    @(posedge clk); #1;
    checkOutput("b2b_result", {28'd0, out_valid, lt, gt, eq}, 32'hA);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("[TB] reset during scan");
    a = 32'h1234_5678; b = 32'h1234_5678; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs", {27'd0, in_ready, out_valid, lt, gt, eq}, 32'h10);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("abort_no_valid", {31'd0, seen_valid}, 32'd0);
    applyStimulus("after_abort", 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 16);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
